// File: rtl/pzcorebus_pkg.sv
// Shared pzcorebus type definitions used by the response sequencer and its bench.
//   pzcorebus_command_type  : command encoding; bit 3 set marks a non-posted command
//   pzcorebus_response_type : response encoding; zero is the idle/null response
package pzcorebus_pkg;

  typedef enum logic [3:0] {
    PZCOREBUS_NULL_COMMAND          = 4'h0,
    PZCOREBUS_MESSAGE               = 4'h1,
    PZCOREBUS_WRITE                 = 4'h2,
    PZCOREBUS_FULL_WRITE            = 4'h3,
    PZCOREBUS_ATOMIC                = 4'h4,
    PZCOREBUS_READ                  = 4'h8,
    PZCOREBUS_MESSAGE_NON_POSTED    = 4'h9,
    PZCOREBUS_WRITE_NON_POSTED      = 4'hA,
    PZCOREBUS_FULL_WRITE_NON_POSTED = 4'hB,
    PZCOREBUS_ATOMIC_NON_POSTED     = 4'hC
  } pzcorebus_command_type;

  typedef enum logic [1:0] {
    PZCOREBUS_NULL_RESPONSE        = 2'd0,
    PZCOREBUS_RESPONSE             = 2'd1,
    PZCOREBUS_RESPONSE_WITH_DATA   = 2'd2
  } pzcorebus_response_type;

  // Non-posted commands are the ones that expect a response.
  function automatic logic is_non_posted_command(input pzcorebus_command_type cmd);
    return cmd[3];
  endfunction

endpackage

// File: rtl/pzcorebus_response_sequencer.sv
// Slave-side response stage for a memory-H profile pzcorebus slave.
// Accepts one command at a time from the slave's command decode and produces
// the matching response on the sresp port. Reads and non-posted atomics are
// split into data beats with per-beat unit enables and a last flag; the data
// itself is passed straight through from the local read data source. Other
// non-posted commands produce a single data-less response; posted commands
// produce nothing.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_mcmd_valid / o_scmd_accept   command handshake
//   i_mcmd, i_mid, i_maddr,
//   i_mlength                      command type, id, byte address, packed length
//   i_rdata_valid / o_rdata_ready  local read data handshake
//   i_rdata                        local read data
//   o_sresp_valid / i_mresp_accept response handshake
//   o_sresp, o_sid, o_sdata,
//   o_sresp_uniten, o_slast        response type, id, data, unit enables, last beat
module pzcorebus_response_sequencer
  import pzcorebus_pkg::*;
#(
  parameter int   ID_WIDTH        = 8,
  parameter int   ADDRESS_WIDTH   = 32,
  parameter int   MAX_LENGTH      = 256,
  parameter int   LENGTH_WIDTH    = $clog2(MAX_LENGTH),
  parameter int   DATA_WIDTH      = 256,
  parameter int   UNIT_DATA_WIDTH = 32,
  localparam int  DATA_SIZE       = DATA_WIDTH / UNIT_DATA_WIDTH
)(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_mcmd_valid,
  output logic                       o_scmd_accept,
  input  pzcorebus_command_type      i_mcmd,
  input  logic [ID_WIDTH-1:0]        i_mid,
  input  logic [ADDRESS_WIDTH-1:0]   i_maddr,
  input  logic [LENGTH_WIDTH-1:0]    i_mlength,
  input  logic                       i_rdata_valid,
  output logic                       o_rdata_ready,
  input  logic [DATA_WIDTH-1:0]      i_rdata,
  output logic                       o_sresp_valid,
  input  logic                       i_mresp_accept,
  output pzcorebus_response_type     o_sresp,
  output logic [ID_WIDTH-1:0]        o_sid,
  output logic [DATA_WIDTH-1:0]      o_sdata,
  output logic [DATA_SIZE-1:0]       o_sresp_uniten,
  output logic                       o_slast
);

  // Offset is kept one bit wide even for single-unit buses; it is then always zero.
  localparam int OFFSET_WIDTH = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam int OFFSET_LSB   = $clog2(UNIT_DATA_WIDTH) - 3;
  // Wide enough to hold both MAX_LENGTH and DATA_SIZE.
  localparam int COUNT_WIDTH  = ((LENGTH_WIDTH > OFFSET_WIDTH) ? LENGTH_WIDTH : OFFSET_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DATA_RESP   = 2'd1,
    NODATA_RESP = 2'd2
  } state_e;

  state_e                   state_r;
  state_e                   state_next_s;
  logic [ID_WIDTH-1:0]      id_r;
  logic [COUNT_WIDTH-1:0]   remaining_r;
  logic [OFFSET_WIDTH-1:0]  offset_r;

  logic                     load_cmd_s;
  logic                     beat_done_s;
  logic [OFFSET_WIDTH-1:0]  read_offset_s;
  logic [COUNT_WIDTH-1:0]   read_length_s;
  logic [COUNT_WIDTH-1:0]   offset_ext_s;
  logic [COUNT_WIDTH-1:0]   avail_s;
  logic [COUNT_WIDTH-1:0]   size_s;
  logic                     last_s;
  logic [DATA_SIZE-1:0]     uniten_s;

  // Only the unit-offset bits of the address matter here.
  logic unused_s;
  assign unused_s = ^i_maddr;

  if (DATA_SIZE > 1) begin : g_offset
    assign read_offset_s = i_maddr[OFFSET_LSB +: OFFSET_WIDTH];
  end else begin : g_no_offset
    assign read_offset_s = {OFFSET_WIDTH{1'b0}};
  end

  // A packed length of zero stands for the maximum burst.
  assign read_length_s = (i_mlength == {LENGTH_WIDTH{1'b0}})
                       ? COUNT_WIDTH'(MAX_LENGTH)
                       : COUNT_WIDTH'(i_mlength);

  // Beat size: units left in the current bus word, capped by units left in the burst.
  always_comb begin
    offset_ext_s = COUNT_WIDTH'(offset_r);
    avail_s      = COUNT_WIDTH'(DATA_SIZE) - offset_ext_s;
    if (remaining_r < avail_s) begin
      size_s = remaining_r;
    end else begin
      size_s = avail_s;
    end
    last_s = (remaining_r == size_s);
  end

  // Unit enables cover [offset, offset + size).
  always_comb begin
    uniten_s = {DATA_SIZE{1'b0}};
    for (int i = 0; i < DATA_SIZE; i++) begin
      uniten_s[i] = (COUNT_WIDTH'(i) >= offset_ext_s) &&
                    (COUNT_WIDTH'(i) < (offset_ext_s + size_s));
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state and response outputs; outputs are a function of state and
  // the live handshake inputs so the first beat costs no extra cycle.
  always_comb begin
    state_next_s   = state_r;
    load_cmd_s     = 1'b0;
    beat_done_s    = 1'b0;
    o_scmd_accept  = 1'b0;
    o_sresp_valid  = 1'b0;
    o_rdata_ready  = 1'b0;
    o_sresp        = PZCOREBUS_NULL_RESPONSE;
    o_sid          = {ID_WIDTH{1'b0}};
    o_sdata        = {DATA_WIDTH{1'b0}};
    o_sresp_uniten = {DATA_SIZE{1'b0}};
    o_slast        = 1'b0;
    case (state_r)
      IDLE: begin
        o_scmd_accept = 1'b1;
        if (i_mcmd_valid) begin
          load_cmd_s = 1'b1;
          if (!is_non_posted_command(i_mcmd)) begin
            state_next_s = IDLE;
          end else if ((i_mcmd == PZCOREBUS_READ) ||
                       (i_mcmd == PZCOREBUS_ATOMIC_NON_POSTED)) begin
            state_next_s = DATA_RESP;
          end else begin
            state_next_s = NODATA_RESP;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      DATA_RESP: begin
        o_sresp_valid  = i_rdata_valid;
        o_rdata_ready  = i_mresp_accept;
        o_sresp        = PZCOREBUS_RESPONSE_WITH_DATA;
        o_sid          = id_r;
        o_sdata        = i_rdata;
        o_sresp_uniten = uniten_s;
        o_slast        = last_s;
        if (i_rdata_valid && i_mresp_accept) begin
          beat_done_s  = 1'b1;
          state_next_s = last_s ? IDLE : DATA_RESP;
        end else begin
          state_next_s = DATA_RESP;
        end
      end
      NODATA_RESP: begin
        o_sresp_valid = 1'b1;
        o_sresp       = PZCOREBUS_RESPONSE;
        o_sid         = id_r;
        o_slast       = 1'b1;
        if (i_mresp_accept) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = NODATA_RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Burst bookkeeping: load on command accept, advance on each completed beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      id_r        <= {ID_WIDTH{1'b0}};
      remaining_r <= {COUNT_WIDTH{1'b0}};
      offset_r    <= {OFFSET_WIDTH{1'b0}};
    end else if (load_cmd_s) begin
      id_r <= i_mid;
      if (i_mcmd == PZCOREBUS_ATOMIC_NON_POSTED) begin
        remaining_r <= COUNT_WIDTH'(DATA_SIZE);
        offset_r    <= {OFFSET_WIDTH{1'b0}};
      end else begin
        remaining_r <= read_length_s;
        offset_r    <= read_offset_s;
      end
    end else if (beat_done_s) begin
      remaining_r <= remaining_r - size_s;
      offset_r    <= {OFFSET_WIDTH{1'b0}};
    end else begin
      remaining_r <= remaining_r;
      offset_r    <= offset_r;
    end
  end

endmodule

// File: tb/tb_pzcorebus_response_sequencer.sv
module tb_pzcorebus_response_sequencer;
  import pzcorebus_pkg::*;

  logic                   clk;
  logic                   rst_n;
  logic                   mcmd_valid;
  logic                   scmd_accept;
  pzcorebus_command_type  mcmd;
  logic [7:0]             mid;
  logic [31:0]            maddr;
  logic [7:0]             mlength;
  logic                   rdata_valid;
  logic                   rdata_ready;
  logic [255:0]           rdata;
  logic                   sresp_valid;
  logic                   mresp_accept;
  pzcorebus_response_type sresp;
  logic [7:0]             sid;
  logic [255:0]           sdata;
  logic [7:0]             sresp_uniten;
  logic                   slast;

  int checks = 0;
  int errors = 0;

  pzcorebus_response_sequencer dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_mcmd_valid   (mcmd_valid),
    .o_scmd_accept  (scmd_accept),
    .i_mcmd         (mcmd),
    .i_mid          (mid),
    .i_maddr        (maddr),
    .i_mlength      (mlength),
    .i_rdata_valid  (rdata_valid),
    .o_rdata_ready  (rdata_ready),
    .i_rdata        (rdata),
    .o_sresp_valid  (sresp_valid),
    .i_mresp_accept (mresp_accept),
    .o_sresp        (sresp),
    .o_sid          (sid),
    .o_sdata        (sdata),
    .o_sresp_uniten (sresp_uniten),
    .o_slast        (slast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                   cmd_valid;
    pzcorebus_command_type  cmd;
    logic [7:0]             id;
    logic [31:0]            addr;
    logic [7:0]             len;
    logic                   rdv;
    logic [255:0]           rd;
    logic                   acc;
    logic                   e_accept;
    logic                   e_valid;
    logic                   e_ready;
    pzcorebus_response_type e_sresp;
    logic [7:0]             e_sid;
    logic [7:0]             e_uniten;
    logic                   e_slast;
    logic                   e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Idle cycle presenting a command.
  function automatic vec_t cmd_v(input pzcorebus_command_type c, input logic [7:0] id,
                                 input logic [31:0] a, input logic [7:0] l);
    vec_t v;
    v = '{cmd_valid:1'b1, cmd:c, id:id, addr:a, len:l, rdv:1'b0, rd:256'd0, acc:1'b0,
          e_accept:1'b1, e_valid:1'b0, e_ready:1'b0, e_sresp:PZCOREBUS_NULL_RESPONSE,
          e_sid:8'h00, e_uniten:8'h00, e_slast:1'b0, e_data:1'b0};
    return v;
  endfunction

  // Idle cycle without a command.
  function automatic vec_t idle_v();
    vec_t v;
    v = cmd_v(PZCOREBUS_NULL_COMMAND, 8'h00, 32'h0, 8'h00);
    v.cmd_valid = 1'b0;
    return v;
  endfunction

  // Response cycle with hand-computed sideband.
  function automatic vec_t beat_v(input logic rdv, input logic [31:0] word, input logic acc,
                                  input pzcorebus_response_type r, input logic [7:0] id,
                                  input logic [7:0] un, input logic last);
    vec_t v;
    v = idle_v();
    v.rdv      = rdv;
    v.rd       = {8{word}};
    v.acc      = acc;
    v.e_accept = 1'b0;
    v.e_valid  = (r == PZCOREBUS_RESPONSE) ? 1'b1 : rdv;
    v.e_ready  = (r == PZCOREBUS_RESPONSE_WITH_DATA) ? acc : 1'b0;
    v.e_sresp  = r;
    v.e_sid    = id;
    v.e_uniten = un;
    v.e_slast  = last;
    v.e_data   = (r == PZCOREBUS_RESPONSE_WITH_DATA);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    mcmd_valid   = v.cmd_valid;
    mcmd         = v.cmd;
    mid          = v.id;
    maddr        = v.addr;
    mlength      = v.len;
    rdata_valid  = v.rdv;
    rdata        = v.rd;
    mresp_accept = v.acc;
  endtask

  task automatic compare(input string tag, input vec_t v);
    check({tag, " accept"}, scmd_accept, v.e_accept);
    check({tag, " valid"},  sresp_valid, v.e_valid);
    check({tag, " ready"},  rdata_ready, v.e_ready);
    check({tag, " sresp"},  sresp,       v.e_sresp);
    check({tag, " sid"},    sid,         v.e_sid);
    check({tag, " uniten"}, sresp_uniten, v.e_uniten);
    check({tag, " slast"},  slast,       v.e_slast);
    check({tag, " sdata"},  sdata,       v.e_data ? v.rd : 256'd0);
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    compare(tag, v);
  endtask

  localparam pzcorebus_response_type WD = PZCOREBUS_RESPONSE_WITH_DATA;
  localparam pzcorebus_response_type RS = PZCOREBUS_RESPONSE;

  initial begin
    vec_t v;
    rst_n = 1'b0;
    drive(idle_v());
    #1;
    compare("reset", idle_v());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: READ 0x14 len 10 -> offset 5: 3 units then 7 units
    vecs.push_back(cmd_v(PZCOREBUS_READ, 8'h03, 32'h14, 8'd10));
    vecs.push_back(beat_v(1'b1, 32'h1111_0001, 1'b1, WD, 8'h03, 8'hE0, 1'b0));
    vecs.push_back(beat_v(1'b1, 32'h1111_0002, 1'b1, WD, 8'h03, 8'h7F, 1'b1));
    vecs.push_back(idle_v());
    // 3: non-posted write, held one cycle, local data offered but never consumed
    vecs.push_back(cmd_v(PZCOREBUS_WRITE_NON_POSTED, 8'h09, 32'h0, 8'd4));
    vecs.push_back(beat_v(1'b1, 32'h3333_0003, 1'b0, RS, 8'h09, 8'h00, 1'b1));
    vecs.push_back(beat_v(1'b1, 32'h3333_0003, 1'b1, RS, 8'h09, 8'h00, 1'b1));
    vecs.push_back(idle_v());
    // 4: posted write then READ next cycle
    vecs.push_back(cmd_v(PZCOREBUS_WRITE, 8'h05, 32'h40, 8'd4));
    vecs.push_back(cmd_v(PZCOREBUS_READ, 8'h06, 32'h0, 8'd1));
    vecs.push_back(beat_v(1'b1, 32'h4444_0004, 1'b1, WD, 8'h06, 8'h01, 1'b1));
    vecs.push_back(idle_v());
    // 5: atomic ignores address offset; first cycle without data
    vecs.push_back(cmd_v(PZCOREBUS_ATOMIC_NON_POSTED, 8'h02, 32'h1C, 8'd3));
    vecs.push_back(beat_v(1'b0, 32'h5555_0005, 1'b1, WD, 8'h02, 8'hFF, 1'b1));
    vecs.push_back(beat_v(1'b1, 32'h5555_0005, 1'b1, WD, 8'h02, 8'hFF, 1'b1));
    vecs.push_back(idle_v());
    // top unit of the word, single unit and crossing into the next word
    vecs.push_back(cmd_v(PZCOREBUS_READ, 8'h07, 32'h1C, 8'd1));
    vecs.push_back(beat_v(1'b1, 32'h6666_0006, 1'b1, WD, 8'h07, 8'h80, 1'b1));
    vecs.push_back(cmd_v(PZCOREBUS_READ, 8'h08, 32'h1C, 8'd3));
    vecs.push_back(beat_v(1'b1, 32'h7777_0007, 1'b1, WD, 8'h08, 8'h80, 1'b0));
    vecs.push_back(beat_v(1'b1, 32'h7777_0008, 1'b1, WD, 8'h08, 8'h03, 1'b1));
    vecs.push_back(idle_v());
    // posted NULL command produces nothing
    vecs.push_back(cmd_v(PZCOREBUS_NULL_COMMAND, 8'h0A, 32'h0, 8'd1));
    vecs.push_back(idle_v());

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
    end

    // 2: maximum-length READ -> 32 full beats
    apply(cmd_v(PZCOREBUS_READ, 8'h01, 32'h0, 8'd0), "max cmd");
    for (int b = 0; b < 32; b++) begin
      apply(beat_v(1'b1, 32'hBEEF_0000 + b, 1'b1, WD, 8'h01, 8'hFF, (b == 31)),
            $sformatf("max b%0d", b));
    end
    apply(idle_v(), "max after");

    // 6: stall on beat0, then reset during beat1
    apply(cmd_v(PZCOREBUS_READ, 8'h04, 32'h14, 8'd10), "rst cmd");
    for (int s = 0; s < 5; s++) begin
      apply(beat_v(1'b1, 32'hCAFE_0000, 1'b0, WD, 8'h04, 8'hE0, 1'b0), $sformatf("stall%0d", s));
    end
    apply(beat_v(1'b1, 32'hCAFE_0000, 1'b1, WD, 8'h04, 8'hE0, 1'b0), "stall done");
    v = beat_v(1'b1, 32'hCAFE_0001, 1'b0, WD, 8'h04, 8'h7F, 1'b1);
    apply(v, "beat1");
    rst_n = 1'b0;
    #1;
    v.e_accept = 1'b1; v.e_valid = 1'b0; v.e_ready = 1'b0; v.e_sresp = PZCOREBUS_NULL_RESPONSE;
    v.e_sid = 8'h00; v.e_uniten = 8'h00; v.e_slast = 1'b0; v.e_data = 1'b0;
    compare("in reset", v);
    @(negedge clk);
    rst_n = 1'b1;
    apply(idle_v(), "post reset");
    apply(cmd_v(PZCOREBUS_READ, 8'h0B, 32'h0, 8'd8), "post cmd");
    apply(beat_v(1'b1, 32'hD00D_0001, 1'b1, WD, 8'h0B, 8'hFF, 1'b1), "post beat");
    apply(idle_v(), "post idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pzcorebus_response_sequencer.md
Name: pzcorebus_response_sequencer

Overview:
Slave-side response stage for memory-H profile pzcorebus. Accepts one command at a time. Splits non-posted commands into response beats using the offset/size/unit-enable rules of the bus, and attaches per-beat sideband to read data coming from the local data source. Sits between the slave's command decode and its sresp port.

Parameters:
ID_WIDTH, 8, mid/sid width
ADDRESS_WIDTH, 32, maddr width
MAX_LENGTH, 256, max burst in units; mlength==0 encodes MAX_LENGTH
LENGTH_WIDTH, $clog2(MAX_LENGTH), packed mlength width
DATA_WIDTH, 256, sdata width
UNIT_DATA_WIDTH, 32, unit size; DATA_SIZE = DATA_WIDTH/UNIT_DATA_WIDTH (power of 2, >=1)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_mcmd_valid  input  1  command valid
o_scmd_accept  output  1  command accept
i_mcmd  input  pzcorebus_command_type  command type
i_mid  input  ID_WIDTH  command id
i_maddr  input  ADDRESS_WIDTH  byte address
i_mlength  input  LENGTH_WIDTH  packed length
i_rdata_valid  input  1  local read data valid
o_rdata_ready  output  1  local read data consumed
i_rdata  input  DATA_WIDTH  local read data
o_sresp_valid  output  1  response valid
i_mresp_accept  input  1  response accept
o_sresp  output  pzcorebus_response_type  RESPONSE / RESPONSE_WITH_DATA
o_sid  output  ID_WIDTH  response id
o_sdata  output  DATA_WIDTH  response data
o_sresp_uniten  output  DATA_SIZE  valid units in beat
o_slast  output  1  last beat of response

Behaviour:
- Reset: state IDLE. o_scmd_accept=1, o_sresp_valid=0, o_rdata_ready=0, o_slast=0, o_sid/o_sresp/o_sresp_uniten/o_sdata=0.
- FSM states: IDLE, DATA_RESP, NODATA_RESP.
- IDLE:
  - o_scmd_accept=1.
  - On i_mcmd_valid, latch mid. Next state by command:
    - posted: stay IDLE; no response.
    - READ or ATOMIC_NON_POSTED: DATA_RESP.
    - other non-posted: NODATA_RESP.
- Command accept is deasserted in DATA_RESP and NODATA_RESP. Back-to-back commands are accepted only from IDLE, so at most one command is in flight.
- Latched on accept for DATA_RESP:
  - remaining (width LENGTH_WIDTH+1):
    - READ: mlength==0 gives MAX_LENGTH, otherwise mlength.
    - ATOMIC: DATA_SIZE.
  - offset slice (width clog2(DATA_SIZE), 0 if DATA_SIZE==1):
    - READ: maddr[clog2(UNIT_DATA_WIDTH)-3 +: width].
    - ATOMIC: 0.
- DATA_RESP, per beat:
  - size = min(DATA_SIZE - offset, remaining).
  - uniten[i] = 1 for offset <= i < offset+size, else 0.
  - o_slast = (remaining == size).
  - o_sresp = RESPONSE_WITH_DATA; o_sdata = i_rdata (combinational pass).
  - o_sresp_valid = i_rdata_valid; o_rdata_ready = i_mresp_accept.
  - A beat completes when i_rdata_valid && i_mresp_accept. On completion: remaining -= size, offset = 0.
  - On completion with slast: go to IDLE; accept is high the next cycle.
- NODATA_RESP:
  - o_sresp_valid=1, o_sresp=RESPONSE, uniten=0, o_slast=1, o_sdata=0.
  - Local data is never consumed.
  - On i_mresp_accept: go to IDLE.
- Backpressure: while o_sresp_valid && !i_mresp_accept, all sideband outputs and state are held stable. o_sdata stability is the data source's obligation (it holds i_rdata while valid and not ready).
- sid equals the latched mid for every beat of a response.
- Zero added latency: the first beat can be valid in the cycle after command accept.
- Reset asserted mid-burst: outputs return to reset values immediately and the burst is dropped. The source must also be reset.
- DATA_SIZE==1: size is always 1, uniten=1, and the number of beats equals the length.

Test Plan:
Defaults DATA_SIZE=8, unit=4 bytes, offset lsb 2.
1. READ, maddr=0x14, mlength=10, id=0x3 -> beat0: uniten=0xE0, slast=0; beat1: uniten=0x7F, slast=1; sid=0x3 both; 2 rdata pops.
2. READ, maddr=0x0, mlength=0 -> 32 beats, each uniten=0xFF; slast only on beat 32; accept high the cycle after.
3. Non-posted WRITE, id=0x9 -> single beat: sresp=RESPONSE, uniten=0x00, slast=1, sid=0x9; o_rdata_ready never asserted.
4. Posted WRITE then READ on the next cycle -> no response for the write; READ accepted at cycle 2, its first beat at cycle 3.
5. ATOMIC_NON_POSTED, maddr=0x1C -> one beat: RESPONSE_WITH_DATA, uniten=0xFF, slast=1 (address offset ignored).
6. READ, length 10, accept held low 5 cycles on beat0 and i_rst_n pulsed low during beat1 -> beat0 outputs stable while stalled; after reset all outputs 0 and o_scmd_accept=1.
